// File: rtl/genius_pkg.sv
// Shared types and helpers for the parametrised Genius datapath.
// The SEQ_ALEATORIA_EN build uses the LFSR constants defined here.
package genius_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    MOSTRA = 2'd1,
    PAUSA  = 2'd2,
    FIM    = 2'd3
  } estado_exib_t;

  // Fibonacci LFSR x^16+x^14+x^13+x^11, feedback taken from bits 0,2,3,5
  localparam logic [15:0] LFSR_SEMENTE = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fluxo_dados_genius_param_if.sv
// Control/status bundle between the Genius control unit and its datapath.
interface fluxo_dados_genius_param_if #(
  parameter int N_BOTOES = 4,
  parameter int AW       = 4
) ();

  logic                zera_rodada;
  logic                conta_rodada;
  logic                zera_endereco;
  logic                conta_endereco;
  logic                registra;
  logic                grava;
  logic                zera_timeout;
  logic                conta_timeout;
  logic                inicia_exibicao;
  logic [N_BOTOES-1:0] botoes;

  logic                jogada_correta;
  logic                endereco_igual_rodada;
  logic                fim_rodada;
  logic                jogada_feita;
  logic                jogada_invalida;
  logic                timeout;
  logic                exibindo;
  logic                fim_exibicao;
  logic [N_BOTOES-1:0] leds;
  logic [AW-1:0]       db_rodada;
  logic [AW-1:0]       db_endereco;
  logic [N_BOTOES-1:0] db_jogada;
  logic [N_BOTOES-1:0] db_memoria;

  modport master (
    output zera_rodada, conta_rodada, zera_endereco, conta_endereco,
           registra, grava, zera_timeout, conta_timeout, inicia_exibicao, botoes,
    input  jogada_correta, endereco_igual_rodada, fim_rodada, jogada_feita,
           jogada_invalida, timeout, exibindo, fim_exibicao, leds,
           db_rodada, db_endereco, db_jogada, db_memoria
  );

  modport slave (
    input  zera_rodada, conta_rodada, zera_endereco, conta_endereco,
           registra, grava, zera_timeout, conta_timeout, inicia_exibicao, botoes,
    output jogada_correta, endereco_igual_rodada, fim_rodada, jogada_feita,
           jogada_invalida, timeout, exibindo, fim_exibicao, leds,
           db_rodada, db_endereco, db_jogada, db_memoria
  );

endinterface

// File: rtl/fluxo_dados_genius_param_exibidor.sv
// Playback engine: walks steps 0..rodada, lighting each for EXIBE_CICLOS
// clocks followed by PAUSA_CICLOS dark clocks, then pulses fim_exibicao.
module exibidor_sequencia
  import genius_pkg::*;
#(
  parameter int AW           = 4,
  parameter int EXIBE_CICLOS = 2000,
  parameter int PAUSA_CICLOS = 500
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inicia,
  input  logic [AW-1:0] rodada,
  output logic [AW-1:0] idx,
  output logic          mostrando,
  output logic          exibindo,
  output logic          fim_exibicao
);

  localparam int MAXC = (EXIBE_CICLOS > PAUSA_CICLOS) ? EXIBE_CICLOS : PAUSA_CICLOS;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] FIM_EXIBE = TW'(EXIBE_CICLOS - 1);
  localparam logic [TW-1:0] FIM_PAUSA = TW'(PAUSA_CICLOS - 1);

  estado_exib_t  estado_q;
  logic [TW-1:0] timer_q;
  logic [AW-1:0] idx_q;

  // rodada is sampled live at the end of each pause
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      timer_q  <= '0;
      idx_q    <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (inicia) begin
            estado_q <= MOSTRA;
            timer_q  <= '0;
            idx_q    <= '0;
          end
        end
        MOSTRA: begin
          if (timer_q == FIM_EXIBE) begin
            estado_q <= PAUSA;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        PAUSA: begin
          if (timer_q == FIM_PAUSA) begin
            timer_q <= '0;
            if (idx_q == rodada) begin
              estado_q <= FIM;
            end else begin
              idx_q    <= idx_q + AW'(1);
              estado_q <= MOSTRA;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        FIM:     estado_q <= OCIOSO;
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign idx          = idx_q;
  assign mostrando    = (estado_q == MOSTRA);
  assign exibindo     = (estado_q == MOSTRA) || (estado_q == PAUSA);
  assign fim_exibicao = (estado_q == FIM);

endmodule

// File: rtl/fluxo_dados_genius_param.sv
// Parametrised Genius datapath: round/address counters, sequence RAM, press
// detection, play timeout and playback. Define SEQ_ALEATORIA_EN for LFSR-generated sequences.
module fluxo_dados_genius_param
  import genius_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int PROFUNDIDADE   = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int EXIBE_CICLOS   = 2000,
  parameter int PAUSA_CICLOS   = 500
) (
  input logic clock,
  input logic reset,
  fluxo_dados_genius_param_if.slave bus
);

  localparam int AW  = $clog2(PROFUNDIDADE);
  localparam int TOW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [AW-1:0]  ULTIMO = AW'(PROFUNDIDADE - 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT_CICLOS - 1);

  logic [AW-1:0]       rodada_q, rodada_d;
  logic [AW-1:0]       endereco_q, endereco_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic [TOW-1:0]      to_q, to_d;
  logic                tem_q, tem_s;
  logic                feita_s;

  logic [AW-1:0]       idx_s;
  logic                mostrando_s, exibindo_s, fim_exib_s;
  logic [AW-1:0]       end_leitura_s;
  logic [N_BOTOES-1:0] dado_lido_s;
  logic [N_BOTOES-1:0] dado_escrita_s;
  logic [N_BOTOES-1:0] mem_q [PROFUNDIDADE];

  always_comb begin
    rodada_d = rodada_q;
    if (bus.zera_rodada) begin
      rodada_d = '0;
    end else if (bus.conta_rodada && (rodada_q != ULTIMO)) begin
      rodada_d = rodada_q + AW'(1);
    end else begin
      rodada_d = rodada_q;
    end

    endereco_d = endereco_q;
    if (bus.zera_endereco) begin
      endereco_d = '0;
    end else if (bus.conta_endereco) begin
      endereco_d = (endereco_q == ULTIMO) ? '0 : endereco_q + AW'(1);
    end else begin
      endereco_d = endereco_q;
    end

    jogada_d = bus.registra ? bus.botoes : jogada_q;

    to_d = to_q;
    if (bus.zera_timeout) begin
      to_d = '0;
    end else if (bus.conta_timeout && (to_q != TO_MAX)) begin
      to_d = to_q + TOW'(1);
    end else begin
      to_d = to_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rodada_q   <= '0;
      endereco_q <= '0;
      jogada_q   <= '0;
      to_q       <= '0;
      tem_q      <= 1'b0;
    end else begin
      rodada_q   <= rodada_d;
      endereco_q <= endereco_d;
      jogada_q   <= jogada_d;
      to_q       <= to_d;
      tem_q      <= tem_s;
    end
  end

`ifdef SEQ_ALEATORIA_EN
  localparam int LW = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] sel_s;

  always_comb begin
    lfsr_d         = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    sel_s          = 32'(lfsr_q[LW-1:0]) % 32'(N_BOTOES);
    dado_escrita_s = N_BOTOES'(1) << sel_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEMENTE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign dado_escrita_s = bus.botoes;
`endif

  // RAM is deliberately not reset; writes are frozen while playback reads it
  always_ff @(posedge clock) begin
    if (bus.grava && !exibindo_s) begin
      mem_q[rodada_q] <= dado_escrita_s;
    end
  end

  assign end_leitura_s = exibindo_s ? idx_s : endereco_q;
  assign dado_lido_s   = mem_q[end_leitura_s];

  exibidor_sequencia #(
    .AW           (AW),
    .EXIBE_CICLOS (EXIBE_CICLOS),
    .PAUSA_CICLOS (PAUSA_CICLOS)
  ) u_exibidor (
    .clock        (clock),
    .reset        (reset),
    .inicia       (bus.inicia_exibicao),
    .rodada       (rodada_q),
    .idx          (idx_s),
    .mostrando    (mostrando_s),
    .exibindo     (exibindo_s),
    .fim_exibicao (fim_exib_s)
  );

  assign tem_s   = |bus.botoes;
  assign feita_s = tem_s & ~tem_q & ~exibindo_s;

  assign bus.jogada_feita          = feita_s;
  assign bus.jogada_invalida       = feita_s && (popcount(32'(bus.botoes)) > 32'd1);
  assign bus.jogada_correta        = (dado_lido_s == jogada_q);
  assign bus.endereco_igual_rodada = (endereco_q == rodada_q);
  assign bus.fim_rodada            = (rodada_q == ULTIMO);
  assign bus.timeout               = (to_q == TO_MAX);
  assign bus.exibindo              = exibindo_s;
  assign bus.fim_exibicao          = fim_exib_s;
  assign bus.leds                  = mostrando_s ? dado_lido_s : '0;
  assign bus.db_rodada             = rodada_q;
  assign bus.db_endereco           = endereco_q;
  assign bus.db_jogada             = jogada_q;
  assign bus.db_memoria            = dado_lido_s;

endmodule

// File: tb/tb_fluxo_dados_genius_param.sv
// Randomised bench for fluxo_dados_genius_param against a cycle-level behavioural model,
// plus directed literal checks. SEQ_ALEATORIA_EN selects the LFSR-sequence model.
`timescale 1ns/1ps
module tb_fluxo_dados_genius_param;

  localparam int NB   = 4;
  localparam int PROF = 16;
  localparam int TO   = 10;
  localparam int EX   = 4;
  localparam int PA   = 2;
  localparam int AW   = 4;
  localparam int PER  = EX + PA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fluxo_dados_genius_param_if #(.N_BOTOES(NB), .AW(AW)) bus ();

  fluxo_dados_genius_param #(
    .N_BOTOES(NB), .PROFUNDIDADE(PROF), .TIMEOUT_CICLOS(TO),
    .EXIBE_CICLOS(EX), .PAUSA_CICLOS(PA)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_rod = 0, m_end = 0, m_to = 0, m_pb_t = 0;
  bit          m_tem = 0, m_pb_act = 0, m_fim = 0;
  logic [3:0]  m_jog = 4'd0;
  logic [3:0]  m_mem [PROF];
  logic [15:0] m_lfsr = 16'hACE1;
  bit          mem_ok = 0;

  function automatic logic [3:0] palavra(input logic [15:0] l, input logic [3:0] b);
`ifdef SEQ_ALEATORIA_EN
    return 4'(1 << (int'(l) % NB));
`else
    return b;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rod <= 0; m_end <= 0; m_to <= 0; m_pb_t <= 0;
      m_tem <= 0; m_pb_act <= 0; m_fim <= 0; m_jog <= 4'd0;
      m_lfsr <= 16'hACE1;
    end else begin
      if (bus.grava && !m_pb_act) m_mem[m_rod] <= palavra(m_lfsr, bus.botoes);
      if (bus.registra) m_jog <= bus.botoes;
      m_tem <= (bus.botoes != 4'd0);
      if (m_pb_act) begin
        if ((m_pb_t % PER) == PER - 1 && ((m_pb_t / PER) % PROF) == m_rod) begin
          m_pb_act <= 0; m_fim <= 1;
        end else m_pb_t <= m_pb_t + 1;
      end else if (m_fim) m_fim <= 0;
      else if (bus.inicia_exibicao) begin m_pb_act <= 1; m_pb_t <= 0; end
      if (bus.zera_rodada) m_rod <= 0;
      else if (bus.conta_rodada) m_rod <= (m_rod < PROF - 1) ? m_rod + 1 : m_rod;
      if (bus.zera_endereco) m_end <= 0;
      else if (bus.conta_endereco) m_end <= (m_end + 1) % PROF;
      if (bus.zera_timeout) m_to <= 0;
      else if (bus.conta_timeout) m_to <= (m_to < TO - 1) ? m_to + 1 : m_to;
      m_lfsr <= (m_lfsr >> 1) | 16'((m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);
    end
  end

  // compare DUT to model mid-cycle
  always @(negedge clk) begin : cmp
    int pidx;
    logic [3:0] rd, e_leds;
    bit feita;
    pidx   = (m_pb_t / PER) % PROF;
    rd     = m_pb_act ? m_mem[pidx] : m_mem[m_end];
    e_leds = (m_pb_act && (m_pb_t % PER) < EX) ? m_mem[pidx] : 4'd0;
    feita  = (bus.botoes != 4'd0) && !m_tem && !m_pb_act;
    check("db_rodada", 32'(bus.db_rodada), 32'(m_rod));
    check("db_endereco", 32'(bus.db_endereco), 32'(m_end));
    check("db_jogada", 32'(bus.db_jogada), 32'(m_jog));
    check("fim_rodada", 32'(bus.fim_rodada), 32'(m_rod == PROF - 1));
    check("end_igual_rod", 32'(bus.endereco_igual_rodada), 32'(m_end == m_rod));
    check("timeout", 32'(bus.timeout), 32'(m_to == TO - 1));
    check("exibindo", 32'(bus.exibindo), 32'(m_pb_act));
    check("fim_exibicao", 32'(bus.fim_exibicao), 32'(m_fim));
    check("jogada_feita", 32'(bus.jogada_feita), 32'(feita));
    check("jogada_invalida", 32'(bus.jogada_invalida), 32'(feita && $countones(bus.botoes) > 1));
    if (mem_ok) begin
      check("leds", 32'(bus.leds), 32'(e_leds));
      check("db_memoria", 32'(bus.db_memoria), 32'(rd));
      check("jogada_correta", 32'(bus.jogada_correta), 32'(rd == m_jog));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.zera_rodada = 1'b0; bus.conta_rodada = 1'b0;
    bus.zera_endereco = 1'b0; bus.conta_endereco = 1'b0;
    bus.registra = 1'b0; bus.grava = 1'b0;
    bus.zera_timeout = 1'b0; bus.conta_timeout = 1'b0;
    bus.inicia_exibicao = 1'b0;
  endtask

  task automatic espera_fim(input string nm);
    bit done;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus.fim_exibicao) done = 1;
    end
    check(nm, 32'(done), 32'd1);
    tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_leds [13];

  initial begin
    idle();
    bus.botoes = 4'd0;
    exp_leds = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0};
    repeat (3) tick();
    @(negedge clk);
    check("rst_leds", 32'(bus.leds), 32'd0);
    check("rst_rodada", 32'(bus.db_rodada), 32'd0);
    check("rst_exibindo", 32'(bus.exibindo), 32'd0);
    check("rst_end_igual", 32'(bus.endereco_igual_rodada), 32'd1);
    tick();
    rst = 1'b0;

    // fill every RAM word so all reads are defined
    for (int i = 0; i < PROF; i++) begin
      bus.grava = 1'b1; bus.conta_rodada = 1'b1;
      bus.botoes = 4'($urandom_range(15));
      tick();
    end
    idle(); bus.botoes = 4'd0; bus.zera_rodada = 1'b1;
    tick();
    idle();
    mem_ok = 1;

    // two-step sequence playback with literal timing
    bus.grava = 1'b1; bus.conta_rodada = 1'b1; bus.botoes = 4'b0001;
    tick();
    bus.conta_rodada = 1'b0; bus.botoes = 4'b0100;
    tick();
    idle(); bus.botoes = 4'd0;
    tick();
    bus.inicia_exibicao = 1'b1;
    tick();
    bus.inicia_exibicao = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
`ifndef SEQ_ALEATORIA_EN
      check($sformatf("seq_leds_%0d", k), 32'(bus.leds), 32'(exp_leds[k-1]));
`endif
      check($sformatf("seq_fim_%0d", k), 32'(bus.fim_exibicao), 32'(k == 13));
      check($sformatf("seq_exib_%0d", k), 32'(bus.exibindo), 32'(k <= 12));
    end
    tick();

    // press detection
    bus.botoes = 4'b0010;
    @(negedge clk);
    check("press_1_feita", 32'(bus.jogada_feita), 32'd1);
    check("press_1_inval", 32'(bus.jogada_invalida), 32'd0);
    tick();
    @(negedge clk);
    check("press_hold", 32'(bus.jogada_feita), 32'd0);
    tick();
    bus.botoes = 4'd0;
    tick();
    bus.botoes = 4'b0110;
    @(negedge clk);
    check("press_2_feita", 32'(bus.jogada_feita), 32'd1);
    check("press_2_inval", 32'(bus.jogada_invalida), 32'd1);
    tick();
    bus.botoes = 4'd0;
    tick();
    bus.inicia_exibicao = 1'b1;
    tick();
    bus.inicia_exibicao = 1'b0;
    tick();
    bus.botoes = 4'b0001;
    @(negedge clk);
    check("press_playback", 32'(bus.jogada_feita), 32'd0);
    tick();
    bus.botoes = 4'd0;
    espera_fim("wait_fim_1");

    // reset in the middle of MOSTRA
    bus.inicia_exibicao = 1'b1;
    tick();
    bus.inicia_exibicao = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_leds", 32'(bus.leds), 32'd0);
    check("midrst_exib", 32'(bus.exibindo), 32'd0);
    check("midrst_rodada", 32'(bus.db_rodada), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    bus.inicia_exibicao = 1'b1;
    tick();
    bus.inicia_exibicao = 1'b0;
    @(negedge clk);
    check("restart_exib", 32'(bus.exibindo), 32'd1);
    espera_fim("wait_fim_2");

    // counter saturation / wrap
    bus.conta_rodada = 1'b1;
    repeat (20) tick();
    bus.conta_rodada = 1'b0;
    @(negedge clk);
    check("rodada_sat", 32'(bus.db_rodada), 32'd15);
    check("fim_rodada_sat", 32'(bus.fim_rodada), 32'd1);
    tick();
    bus.zera_endereco = 1'b1;
    tick();
    bus.zera_endereco = 1'b0; bus.conta_endereco = 1'b1;
    repeat (16) tick();
    bus.conta_endereco = 1'b0;
    @(negedge clk);
    check("endereco_wrap", 32'(bus.db_endereco), 32'd0);
    tick();

    // timeout saturation and clear
    bus.zera_timeout = 1'b1;
    tick();
    bus.zera_timeout = 1'b0; bus.conta_timeout = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("timeout_%0d", k), 32'(bus.timeout), 32'(k >= TO - 1));
    end
    tick();
    bus.conta_timeout = 1'b0; bus.zera_timeout = 1'b1;
    tick();
    bus.zera_timeout = 1'b0;
    @(negedge clk);
    check("timeout_clear", 32'(bus.timeout), 32'd0);
    tick();

`ifdef SEQ_ALEATORIA_EN
    bus.zera_rodada = 1'b1;
    tick();
    bus.zera_rodada = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.grava = 1'b1; bus.conta_rodada = 1'b1;
      tick();
    end
    idle(); bus.zera_endereco = 1'b1;
    tick();
    bus.zera_endereco = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("lfsr_onehot_%0d", i), 32'($onehot(bus.db_memoria)), 32'd1);
      check($sformatf("lfsr_word_%0d", i), 32'(bus.db_memoria), 32'(m_mem[i]));
      tick();
      bus.conta_endereco = 1'b1;
      tick();
      bus.conta_endereco = 1'b0;
    end
`endif

    // randomised traffic
    for (int c = 0; c < 1500; c++) begin
      bus.zera_rodada     = ($urandom_range(99) < 3);
      bus.conta_rodada    = ($urandom_range(99) < 12);
      bus.zera_endereco   = ($urandom_range(99) < 5);
      bus.conta_endereco  = ($urandom_range(99) < 25);
      bus.registra        = ($urandom_range(99) < 15);
      bus.grava           = ($urandom_range(99) < 10);
      bus.zera_timeout    = ($urandom_range(99) < 5);
      bus.conta_timeout   = ($urandom_range(99) < 50);
      bus.inicia_exibicao = ($urandom_range(99) < 3);
      bus.botoes          = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
      tick();
    end
    idle();
    bus.botoes = 4'd0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fluxo_dados_genius_param.md
Name: fluxo_dados_genius_param

Overview:
- Parametrised next-generation datapath for the memory (Genius) game.
- Generalised in button count, sequence depth and timeout lengths.
- Adds behaviour the previous datapath lacks:
  - internal sequence-playback engine that shows every stored step up to the current round on the LEDs;
  - multi-press rejection;
  - a saturating round counter.
- Sits between the game control unit (unidade_controle) and the board buttons/LEDs.

Parameters:
- N_BOTOES, 4, number of buttons/LEDs, also the stored word width.
- PROFUNDIDADE, 16, maximum sequence length (RAM depth); AW = $clog2(PROFUNDIDADE).
- TIMEOUT_CICLOS, 5000, play timeout in clocks.
- EXIBE_CICLOS, 2000, clocks each step is lit during playback.
- PAUSA_CICLOS, 500, dark clocks between playback steps.

Ports:
- clock in 1, system clock.
- reset in 1, asynchronous, active-high.
- zera_rodada / conta_rodada in 1/1, round counter sync clear / increment.
- zera_endereco / conta_endereco in 1/1, address counter sync clear / increment.
- registra in 1, load jogada register from botoes.
- grava in 1, write botoes into RAM at address rodada.
- zera_timeout / conta_timeout in 1/1, timeout counter control.
- inicia_exibicao in 1, start playback of steps 0..rodada.
- botoes in N_BOTOES, raw button inputs, already synchronised.
- jogada_correta out 1, RAM[endereco] == jogada.
- endereco_igual_rodada out 1, endereco == rodada.
- fim_rodada out 1, rodada == PROFUNDIDADE-1.
- jogada_feita out 1, one-clock pulse on button press.
- jogada_invalida out 1, asserted together with jogada_feita when more than one button is pressed.
- timeout out 1, play timeout reached.
- exibindo out 1, playback active.
- fim_exibicao out 1, one-clock pulse at the end of playback.
- leds out N_BOTOES, LED drive.
- db_rodada, db_endereco out AW; db_jogada, db_memoria out N_BOTOES; debug outputs.

Behaviour:
- Reset values:
  - All counters, the jogada register, the edge-detect flop and the playback FSM are cleared.
  - Every output is 0, except comparator outputs, which follow their cleared operands.
  - RAM contents are not cleared.
- Counters:
  - zera has priority over conta.
  - rodada saturates at PROFUNDIDADE-1.
  - endereco wraps from PROFUNDIDADE-1 to 0.
- RAM:
  - Combinational read.
  - Synchronous write when grava=1 and exibindo=0; grava is ignored while exibindo=1.
  - Read address: playback index while exibindo=1, otherwise endereco.
  - Write address: always rodada.
- Jogada register: loads botoes when registra=1; clear on reset only.
- Comparisons: jogada_correta and endereco_igual_rodada are combinational.
- Press detection:
  - tem = |botoes, registered into tem_d.
  - jogada_feita = tem & ~tem_d, forced to 0 while exibindo.
  - jogada_invalida = jogada_feita & (popcount(botoes) > 1).
- Timeout counter:
  - Counts when conta_timeout=1 and saturates at TIMEOUT_CICLOS-1.
  - timeout = (count == TIMEOUT_CICLOS-1), held until zera_timeout.
- Playback FSM, states OCIOSO, MOSTRA, PAUSA, FIM:
  - OCIOSO: inicia_exibicao=1 clears idx and the timer, then goes to MOSTRA. inicia_exibicao in any other state is ignored.
  - MOSTRA: leds = RAM[idx]. After EXIBE_CICLOS clocks, go to PAUSA.
  - PAUSA: leds = 0. After PAUSA_CICLOS clocks: if idx == rodada go to FIM, else idx++ and go to MOSTRA.
  - FIM: fim_exibicao=1 for one clock, then OCIOSO.
  - exibindo = 1 in MOSTRA and PAUSA.
  - Total playback latency from start to fim_exibicao: (rodada+1)*(EXIBE_CICLOS+PAUSA_CICLOS)+1 clocks.
  - leds = 0 outside MOSTRA.
  - rodada changing mid-playback: the comparison uses the live value.
  - reset mid-playback: immediate return to OCIOSO with leds = 0.

Optional Feature:
- Macro: SEQ_ALEATORIA_EN.
- When defined:
  - Adds a free-running 16-bit LFSR, seed 16'hACE1 on reset, advancing every clock.
  - grava writes the one-hot word 1 << (lfsr[log2(N_BOTOES)-1:0] mod N_BOTOES) instead of botoes, so the machine generates the sequence.
- When undefined: grava writes botoes, and no LFSR logic exists.

Decomposition:
- Package genius_pkg holds:
  - the playback state enum (OCIOSO, MOSTRA, PAUSA, FIM);
  - the LFSR seed and taps constants;
  - a popcount function.
- One natural sub-module: exibidor_sequencia, containing the playback FSM, step timer and idx counter.
- Counters, RAM and press detection stay inline.

Test Plan:
1. Reset mid-MOSTRA -> leds=0, exibindo=0 and rodada=0 immediately; FSM in OCIOSO.
2. Write sequence with N_BOTOES=4, EXIBE=4, PAUSA=2: grava 4'b0001 at rodada 0, then 4'b0100 at rodada 1. With rodada=1, pulse inicia_exibicao ->
   - leds=0001 for 4 clocks, 0 for 2 clocks, 0100 for 4 clocks, 0 for 2 clocks;
   - fim_exibicao pulses at clock 13.
3. Press 4'b0010 -> jogada_feita 1 clock, jogada_invalida 0. Press 4'b0110 -> both pulse. Press during playback -> no pulse.
4. conta_rodada for 20 clocks with PROFUNDIDADE=16 -> rodada holds 15, fim_rodada=1. conta_endereco 16 times from 0 -> endereco=0.
5. conta_timeout held with TIMEOUT=10 -> timeout=1 after 9 clocks and stays high; zera_timeout -> 0 next clock.
6. SEQ_ALEATORIA_EN defined: grava for 8 rounds -> every stored word is one-hot and matches the reference LFSR model from seed 16'hACE1.
